sysid_checker: RTL and testbench

- Avalon-MM read master that sits directly downstream of the Qsys system-ID slave and consumes its two words.
- Word 0 is the system ID; word 1 is the generation timestamp.
- After reset, or on request, it reads both words, compares them with build-time expected values and publishes the captured values plus pass/fail/timeout flags.
- Lets fabric logic and the HPS bridge detect a bitstream/software mismatch without a CPU read.

---
 rtl/sysid_checker_pkg.sv | 19 +
 rtl/sysid_checker_timer.sv | 37 +++
 rtl/sysid_checker.sv | 187 ++++++++++++++++++
 tb/tb_sysid_checker.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_checker_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMER_W = 16;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/sysid_checker_timer.sv
// Per-transaction watchdog: clearable, enabled counter with a terminal-count flag.
module sysid_checker_timer
  import sysid_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c
);

  localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_c = (count_q == TC_VAL);

endmodule

// File: rtl/sysid_checker.sv
// Reads the Qsys system-ID words over Avalon-MM and flags a mismatch against
// build-time expected values, with a per-read watchdog.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1457919206,
  parameter bit          USE_RDV        = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout
);

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic              avm_read_q, avm_read_d;
  logic              avm_address_q, avm_address_d;
  logic [DATA_W-1:0] id_value_q, id_value_d;
  logic [DATA_W-1:0] ts_value_q, ts_value_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              id_ok_q, id_ok_d;
  logic              ts_ok_q, ts_ok_d;
  logic              timeout_q, timeout_d;
  logic              finish, abort;
  logic              tmr_clr, tmr_en, tmr_tc;

  sysid_checker_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clock),
    .rst_n(reset_n),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_c (tmr_tc)
  );

  // Next state, captures and flags; completion is checked before the watchdog.
  always_comb begin
    state_d    = state_q;
    armed_d    = 1'b1;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    busy_d     = busy_q;
    done_d     = done_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    finish     = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start || (AUTO_START && !armed_q)) begin
          state_d = RD_ID;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          if (USE_RDV) begin
            state_d = WT_ID;
          end else begin
            id_value_d = avm_readdata;
            state_d    = RD_TS;
          end
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      WT_ID: begin
        if (avm_readdatavalid) begin
          id_value_d = avm_readdata;
          state_d    = RD_TS;
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          if (USE_RDV) begin
            state_d = WT_TS;
          end else begin
            ts_value_d = avm_readdata;
            finish     = 1'b1;
          end
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      WT_TS: begin
        if (avm_readdatavalid) begin
          ts_value_d = avm_readdata;
          finish     = 1'b1;
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RD_ID;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = DONE;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      timeout_d = 1'b1;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
    end else if (finish) begin
      state_d = DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      id_ok_d = (id_value_d == EXPECTED_ID);
      ts_ok_d = (ts_value_d == EXPECTED_TS);
    end else if ((state_d == RD_ID) && (state_q != RD_ID)) begin
      busy_d    = 1'b1;
      done_d    = 1'b0;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b0;
    end

    avm_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    avm_address_d = (state_d == RD_TS) ? ADDR_TS : ADDR_ID;
    tmr_clr       = avm_read_d && (state_d != state_q);
    tmr_en        = (state_q == RD_ID) || (state_q == WT_ID) ||
                    (state_q == RD_TS) || (state_q == WT_TS);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      avm_read_q    <= 1'b0;
      avm_address_q <= ADDR_ID;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: instance 0 is zero-latency (timeout 8), instance 1
// uses readdatavalid (timeout 16); a behavioural slave serves both.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1457919206;

  typedef struct {
    int          dut;
    int          w0, w1, l0, l1;
    logic [31:0] d0, d1;
    int          poke;
    logic [31:0] eid, ets;
    logic        eidok, etsok, eto;
    int          elat;
  } vec_t;

  logic        clk, reset_n;
  logic        start [2];
  logic        avm_address [2], avm_read [2], waitreq [2], rdv [2];
  logic [31:0] rdata [2], id_value [2], ts_value [2];
  logic        busy [2], done [2], id_ok [2], ts_ok [2], timeout [2];

  int          pw0 [2], pw1 [2], pl0 [2], pl1 [2];
  logic [31:0] pd0 [2], pd1 [2];
  logic        spur [2];
  logic [31:0] prev_id [2], prev_ts [2];

  int total = 0;
  int bad   = 0;

  sysid_checker #(.USE_RDV(1'b0), .TIMEOUT_CYCLES(8)) dut_a (
    .clock(clk), .reset_n(reset_n), .start(start[0]),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]),
    .avm_waitrequest(waitreq[0]), .avm_readdata(rdata[0]),
    .avm_readdatavalid(rdv[0]),
    .id_value(id_value[0]), .ts_value(ts_value[0]), .busy(busy[0]),
    .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .timeout(timeout[0])
  );

  sysid_checker #(.USE_RDV(1'b1), .TIMEOUT_CYCLES(16)) dut_b (
    .clock(clk), .reset_n(reset_n), .start(start[1]),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]),
    .avm_waitrequest(waitreq[1]), .avm_readdata(rdata[1]),
    .avm_readdatavalid(rdv[1]),
    .id_value(id_value[1]), .ts_value(ts_value[1]), .busy(busy[1]),
    .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .timeout(timeout[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave: stalls w cycles per read, then answers at once (inst 0) or L cycles later (inst 1).
  initial begin
    int   stall [2];
    int   rcnt [2];
    logic raddr [2];
    logic last_rd [2], last_wt [2], last_ad [2];
    for (int i = 0; i < 2; i++) begin
      stall[i] = 0; rcnt[i] = 0; raddr[i] = 1'b0;
      last_rd[i] = 1'b0; last_wt[i] = 1'b0; last_ad[i] = 1'b0;
      waitreq[i] = 1'b0; rdv[i] = 1'b0; rdata[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset_n) begin
          stall[i] = 0; rcnt[i] = 0; last_rd[i] = 1'b0; last_wt[i] = 1'b0;
          waitreq[i] = 1'b0; rdv[i] = 1'b0;
        end else begin
          if (last_rd[i] && !last_wt[i]) begin
            stall[i] = 0;
            if (i == 1) begin
              rcnt[i]  = last_ad[i] ? pl1[i] : pl0[i];
              raddr[i] = last_ad[i];
            end
          end else if (last_rd[i]) begin
            stall[i]++;
          end else begin
            stall[i] = 0;
          end
          waitreq[i] = avm_read[i] && (stall[i] < (avm_address[i] ? pw1[i] : pw0[i]));
          rdv[i] = 1'b0;
          if (i == 0) rdata[i] = avm_address[i] ? pd1[i] : pd0[i];
          else        rdata[i] = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
          if (rcnt[i] > 0) begin
            rcnt[i]--;
            if (rcnt[i] == 0) begin
              rdv[i]   = 1'b1;
              rdata[i] = raddr[i] ? pd1[i] : pd0[i];
            end
          end
          if (spur[i]) begin
            rdv[i]   = 1'b1;
            rdata[i] = 32'hFFFF_FFFF;
            spur[i]  = 1'b0;
          end
          last_rd[i] = avm_read[i];
          last_wt[i] = waitreq[i];
          last_ad[i] = avm_address[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int tmo(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int dur(input int i, input int w, input int l);
    return (i == 1) ? (w + l + 1) : (w + 1);
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic vec_t mk(input int dut, input int w0, input int w1, input int l0,
                              input int l1, input logic [31:0] d0, input logic [31:0] d1,
                              input int poke, input logic [31:0] eid, input logic [31:0] ets,
                              input logic eidok, input logic etsok, input logic eto,
                              input int elat);
    vec_t v;
    v.dut = dut; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1; v.d0 = d0; v.d1 = d1;
    v.poke = poke; v.eid = eid; v.ets = ets; v.eidok = eidok; v.etsok = etsok;
    v.eto = eto; v.elat = elat;
    return v;
  endfunction

  // Reference: each read either completes within the timeout budget or aborts the check.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    int   t, d0, d1;
    r  = v;
    t  = tmo(v.dut);
    d0 = dur(v.dut, v.w0, v.l0);
    d1 = dur(v.dut, v.w1, v.l1);
    r.eid = prev_id[v.dut]; r.ets = prev_ts[v.dut];
    r.eidok = 1'b0; r.etsok = 1'b0; r.eto = 1'b1;
    if (d0 > t) begin
      r.elat = 1 + t;
    end else begin
      r.eid = v.d0;
      if (d1 > t) begin
        r.elat = 1 + d0 + t;
      end else begin
        r.ets   = v.d1;
        r.eto   = 1'b0;
        r.elat  = 1 + d0 + d1;
        r.eidok = (r.eid == EXP_ID);
        r.etsok = (r.ets == EXP_TS);
      end
    end
    return r;
  endfunction

  task automatic set_plan(input vec_t v);
    pw0[v.dut] = v.w0; pw1[v.dut] = v.w1; pl0[v.dut] = v.l0; pl1[v.dut] = v.l1;
    pd0[v.dut] = v.d0; pd1[v.dut] = v.d1;
  endtask

  // Called just after a falling edge; optionally pulses start, then waits for done.
  task automatic apply(input vec_t v, input bit do_start, input string tag);
    int i, n, rc0, rc1, t, e0, e1;
    bit seen;
    i = v.dut; n = 0; rc0 = 0; rc1 = 0; seen = 1'b0; t = tmo(i);
    e0 = min2(v.w0 + 1, t);
    e1 = (dur(i, v.w0, v.l0) <= t) ? min2(v.w1 + 1, t) : 0;
    set_plan(v);
    if (do_start) start[i] = 1'b1;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      start[i] = (v.poke != 0) && (n == v.poke);
      if (n == 1)
        chk({tag, "_clr"}, 32'({busy[i], done[i], id_ok[i], ts_ok[i], timeout[i]}), 32'b10000);
      if (avm_read[i]) begin
        if (avm_address[i]) rc1++;
        else                rc0++;
      end
      seen = done[i];
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_done: no done after %0d cycles", tag, n);
    end else begin
      chk({tag, "_lat"},   32'(n), 32'(v.elat));
      chk({tag, "_rd0"},   32'(rc0), 32'(e0));
      chk({tag, "_rd1"},   32'(rc1), 32'(e1));
      chk({tag, "_id"},    id_value[i], v.eid);
      chk({tag, "_ts"},    ts_value[i], v.ets);
      chk({tag, "_flags"}, 32'({busy[i], id_ok[i], ts_ok[i], timeout[i]}),
          32'({1'b0, v.eidok, v.etsok, v.eto}));
    end
    start[i] = 1'b0;
    if (v.poke != 0) begin
      repeat (3) @(negedge clk);
      chk({tag, "_noq"}, 32'({busy[i], done[i]}), 32'b01);
    end
    prev_id[i] = v.eid;
    prev_ts[i] = v.ets;
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_ctl"}, 32'({avm_read[i], avm_address[i], busy[i], done[i],
                            id_ok[i], ts_ok[i], timeout[i]}), 32'd0);
    chk({tag, "_idv"}, id_value[i], 32'd0);
    chk({tag, "_tsv"}, ts_value[i], 32'd0);
  endtask

  initial begin
    vec_t tbl [8];
    vec_t v, va, vb;

    va = mk(0, 0, 0, 0, 0, EXP_ID, EXP_TS, 0, EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0, 3);
    vb = mk(1, 0, 0, 3, 3, EXP_ID, EXP_TS, 0, EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0, 9);
    tbl[0] = mk(0, 0, 0, 0, 0, 32'h1, EXP_TS, 0, 32'h1, EXP_TS, 1'b0, 1'b1, 1'b0, 3);
    tbl[1] = mk(0, 0, 5, 0, 0, EXP_ID, EXP_TS, 3, EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0, 8);
    tbl[2] = mk(0, 8, 0, 0, 0, 32'h77, 32'h88, 0, EXP_ID, EXP_TS, 1'b0, 1'b0, 1'b1, 9);
    tbl[3] = mk(0, 2, 7, 0, 0, EXP_ID, 32'h1234, 0, EXP_ID, 32'h1234, 1'b1, 1'b0, 1'b0, 12);
    tbl[4] = mk(0, 0, 8, 0, 0, 32'h5, EXP_TS, 0, 32'h5, 32'h1234, 1'b0, 1'b0, 1'b1, 10);
    tbl[5] = mk(1, 0, 0, 3, 3, EXP_ID, EXP_TS, 0, EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0, 9);
    tbl[6] = mk(1, 2, 1, 13, 1, 32'hAB, EXP_TS, 0, 32'hAB, EXP_TS, 1'b0, 1'b1, 1'b0, 20);
    tbl[7] = mk(1, 0, 0, 16, 1, 32'h0, 32'h0, 0, 32'hAB, EXP_TS, 1'b0, 1'b0, 1'b1, 17);

    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; spur[i] = 1'b0; prev_id[i] = '0; prev_ts[i] = '0;
    end
    set_plan(va);
    set_plan(vb);
    repeat (3) @(negedge clk);
    chk_zero(0, "rst_a");
    chk_zero(1, "rst_b");

    reset_n = 1'b1;
    fork
      apply(va, 1'b0, "auto_a");
      apply(vb, 1'b0, "auto_b");
    join
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      apply(tbl[k], 1'b1, $sformatf("tbl%0d", k));
      @(negedge clk);
    end

    // Stray readdatavalid while the checker sits in DONE must not disturb the captures.
    @(posedge clk);
    #1 spur[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("spur_id", id_value[1], 32'hAB);
    chk("spur_ts", ts_value[1], EXP_TS);
    chk("spur_done", 32'({busy[1], done[1]}), 32'b01);

    for (int k = 0; k < 12; k++) begin
      v.dut  = k % 2;
      v.w0   = (v.dut == 0) ? $urandom_range(0, 9) : $urandom_range(0, 4);
      v.w1   = (v.dut == 0) ? $urandom_range(0, 9) : $urandom_range(0, 4);
      v.l0   = $urandom_range(1, 13);
      v.l1   = $urandom_range(1, 13);
      v.d0   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_ID;
      v.d1   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_TS;
      v.poke = 0;
      v      = predict(v);
      apply(v, 1'b1, $sformatf("rnd%0d", k));
      @(negedge clk);
    end

    // Reset pulse in the middle of a stalled ID read.
    pw0[0] = 1000;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_stall", 32'(avm_read[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_zero(0, "mr_a");
    chk_zero(1, "mr_b");
    set_plan(va);
    set_plan(vb);
    @(negedge clk);
    reset_n = 1'b1;
    fork
      apply(va, 1'b0, "rr_a");
      apply(vb, 1'b0, "rr_b");
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
